// File: rtl/traffic_light_ctrl_param.sv
// Round-robin N-approach intersection controller: green/yellow/all-red phases,
// demand skipping, emergency preemption and night flashing mode.
module traffic_light_ctrl_param #(
  parameter int unsigned NUM_WAYS   = 4,
  parameter int unsigned GREEN_CYC  = 20,
  parameter int unsigned YELLOW_CYC = 5,
  parameter int unsigned ALLRED_CYC = 2,
  parameter int unsigned FLASH_HALF = 8,
  localparam int unsigned IW = (NUM_WAYS > 2) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_WAYS-1:0]   demand,
  input  logic                  skip_en,
  input  logic                  preempt,
  input  logic [IW-1:0]         preempt_way,
  input  logic                  flash_mode,
  output logic [3*NUM_WAYS-1:0] light,
  output logic [IW-1:0]         active_way,
  output logic [1:0]            phase
);

  localparam int unsigned MAX_GY  = (GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC;
  localparam int unsigned MAX_AF  = (ALLRED_CYC > FLASH_HALF) ? ALLRED_CYC : FLASH_HALF;
  localparam int unsigned MAX_DUR = (MAX_GY > MAX_AF) ? MAX_GY : MAX_AF;
  localparam int unsigned TW      = $clog2(MAX_DUR) + 1;

  localparam logic [TW-1:0] G_LAST = TW'(GREEN_CYC - 1);
  localparam logic [TW-1:0] Y_LAST = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] A_LAST = TW'(ALLRED_CYC - 1);
  localparam logic [TW-1:0] F_LAST = TW'(FLASH_HALF - 1);
  localparam logic [IW:0]   NW_EXT = (IW + 1)'(NUM_WAYS);
  localparam logic [IW-1:0] W_LAST = IW'(NUM_WAYS - 1);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10,
    PH_FLASH  = 2'b11
  } phase_e;

  phase_e        phase_q, phase_d;
  logic [IW-1:0] way_q, way_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          blink_q, blink_d;
  logic          fexit_q, fexit_d;

  logic          pre_vld;
  logic [IW-1:0] next_way;
  logic [IW-1:0] skip_way;
  logic [IW-1:0] idx;

  assign pre_vld  = preempt && ({1'b0, preempt_way} < NW_EXT);
  assign next_way = (way_q == W_LAST) ? '0 : way_q + 1'b1;

  // Scan downward so the nearest approach after the current one wins.
  always_comb begin
    skip_way = next_way;
    idx      = '0;
    for (int unsigned k = NUM_WAYS; k > 0; k--) begin
      idx = IW'((32'(way_q) + k) % NUM_WAYS);
      if (demand[idx]) skip_way = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_GREEN;
      way_q   <= '0;
      tmr_q   <= '0;
      blink_q <= 1'b1;
      fexit_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      way_q   <= way_d;
      tmr_q   <= tmr_d;
      blink_q <= blink_d;
      fexit_q <= fexit_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    way_d   = way_q;
    tmr_d   = tmr_q + 1'b1;
    blink_d = blink_q;
    fexit_d = fexit_q;
    unique case (phase_q)
      PH_GREEN: begin
        if (flash_mode || (pre_vld && (preempt_way != way_q))) begin
          phase_d = PH_YELLOW;
          tmr_d   = '0;
        end else if (pre_vld) begin
          // Preempt toward the current owner freezes the timer; counting resumes later.
          tmr_d = tmr_q;
        end else if (tmr_q == G_LAST) begin
          phase_d = PH_YELLOW;
          tmr_d   = '0;
        end
      end
      PH_YELLOW: begin
        if (tmr_q == Y_LAST) begin
          phase_d = PH_ALLRED;
          tmr_d   = '0;
        end
      end
      PH_ALLRED: begin
        if (tmr_q == A_LAST) begin
          tmr_d   = '0;
          fexit_d = 1'b0;
          if (flash_mode) begin
            phase_d = PH_FLASH;
            blink_d = 1'b1;
          end else begin
            phase_d = PH_GREEN;
            if (fexit_q)                    way_d = '0;
            else if (pre_vld)               way_d = preempt_way;
            else if (skip_en && |demand)    way_d = skip_way;
            else                            way_d = next_way;
          end
        end
      end
      PH_FLASH: begin
        if (!flash_mode) begin
          phase_d = PH_ALLRED;
          tmr_d   = '0;
          fexit_d = 1'b1;
        end else if (tmr_q == F_LAST) begin
          tmr_d   = '0;
          blink_d = ~blink_q;
        end
      end
      default: phase_d = PH_GREEN;
    endcase
  end

  always_comb begin
    light = '0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      unique case (phase_q)
        PH_GREEN:  light[3*(NUM_WAYS-1-i) +: 3] = (IW'(i) == way_q) ? 3'b100 : 3'b001;
        PH_YELLOW: light[3*(NUM_WAYS-1-i) +: 3] = (IW'(i) == way_q) ? 3'b010 : 3'b001;
        PH_ALLRED: light[3*(NUM_WAYS-1-i) +: 3] = 3'b001;
        PH_FLASH:  light[3*(NUM_WAYS-1-i) +: 3] = blink_q ? 3'b010 : 3'b000;
        default:   light[3*(NUM_WAYS-1-i) +: 3] = 3'b001;
      endcase
    end
  end

  assign active_way = way_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Bench for traffic_light_ctrl_param: randomized scenarios checked against a
// timeline model derived from phase durations and the approach-selection rules.
module tb_traffic_light_ctrl_param;

  localparam int N = 4, G = 20, Y = 5, AR = 2, FH = 8, SLOT = 27;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, skip_en, preempt, flash_mode;
  logic [3:0]  demand;
  logic [1:0]  preempt_way;
  logic [11:0] light;
  logic [1:0]  active_way, phase;

  logic        rst_b, skip_en_b, preempt_b, flash_b;
  logic [2:0]  demand_b;
  logic [1:0]  preempt_way_b;
  logic [8:0]  light_b;
  logic [1:0]  active_way_b, phase_b;

  int checks = 0;
  int errors = 0;

  traffic_light_ctrl_param dut (
    .clk(clk), .rst(rst), .demand(demand), .skip_en(skip_en), .preempt(preempt),
    .preempt_way(preempt_way), .flash_mode(flash_mode), .light(light),
    .active_way(active_way), .phase(phase)
  );

  traffic_light_ctrl_param #(
    .NUM_WAYS(3), .GREEN_CYC(1), .YELLOW_CYC(1), .ALLRED_CYC(1), .FLASH_HALF(8)
  ) dut_small (
    .clk(clk), .rst(rst_b), .demand(demand_b), .skip_en(skip_en_b), .preempt(preempt_b),
    .preempt_way(preempt_way_b), .flash_mode(flash_b), .light(light_b),
    .active_way(active_way_b), .phase(phase_b)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic int slot_phase(int off);
    if (off < G) return 0;
    if (off < G + Y) return 1;
    return 2;
  endfunction

  function automatic logic [11:0] exp_light(int n, int ph, int w, bit blink);
    logic [11:0] v;
    logic [2:0]  g;
    v = '0;
    for (int i = 0; i < n; i++) begin
      case (ph)
        0:       g = (i == w) ? 3'b100 : 3'b001;
        1:       g = (i == w) ? 3'b010 : 3'b001;
        2:       g = 3'b001;
        default: g = blink ? 3'b010 : 3'b000;
      endcase
      v[3*(n-1-i) +: 3] = g;
    end
    return v;
  endfunction

  function automatic int nonred(logic [11:0] l, int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (l[3*i +: 3] != 3'b001) c++;
    return c;
  endfunction

  task automatic test_reset();
    logic [11:0] exp_l;
    demand = '0; skip_en = 0; preempt = 0; preempt_way = '0; flash_mode = 0;
    do_reset();
    exp_l = 12'b100_001_001_001;
    checks++;
    if (phase !== 2'b00) begin errors++; $display("FAIL reset_phase got %0d exp 0", phase); end
    checks++;
    if (active_way !== 2'd0) begin errors++; $display("FAIL reset_way got %0d exp 0", active_way); end
    checks++;
    if (light !== exp_l) begin errors++; $display("FAIL reset_light got %b exp %b", light, exp_l); end
  endtask

  task automatic test_rotation();
    skip_en = 0; preempt = 0; flash_mode = 0;
    do_reset();
    for (int t = 0; t <= 4 * SLOT; t++) begin
      int ph, w;
      ph = slot_phase(t % SLOT);
      w  = (t / SLOT) % N;
      checks++;
      if ({phase, active_way, light} !== {2'(ph), 2'(w), exp_light(N, ph, w, 0)}) begin
        errors++;
        $display("FAIL rotation t=%0d got ph=%0d way=%0d light=%b exp ph=%0d way=%0d", t, phase, active_way, light, ph, w);
      end
      demand = 4'($urandom);
      tick();
    end
  endtask

  task automatic test_skip();
    for (int it = 0; it < 4; it++) begin
      logic [3:0] mask;
      int ws[5];
      mask = (it == 0) ? 4'b0100 : 4'($urandom_range(1, 15));
      demand = mask; skip_en = 1; preempt = 0; flash_mode = 0;
      do_reset();
      ws[0] = 0;
      for (int k = 1; k < 5; k++) begin
        ws[k] = -1;
        for (int d = N; d >= 1; d--) if (mask[(ws[k-1] + d) % N]) ws[k] = (ws[k-1] + d) % N;
      end
      for (int t = 0; t <= 4 * SLOT; t++) begin
        int ph, w;
        ph = slot_phase(t % SLOT);
        w  = ws[t / SLOT];
        checks++;
        if ({phase, active_way, light} !== {2'(ph), 2'(w), exp_light(N, ph, w, 0)}) begin
          errors++;
          $display("FAIL skip mask=%b t=%0d got ph=%0d way=%0d exp ph=%0d way=%0d", mask, t, phase, active_way, ph, w);
        end
        tick();
      end
    end
  endtask

  task automatic test_preempt();
    for (int it = 0; it < 3; it++) begin
      int c, e, pw;
      c  = (it == 0) ? 5 : ((it == 1) ? 19 : int'($urandom_range(0, 19)));
      e  = c + 8 + int'($urandom_range(0, 12));
      pw = (it == 0) ? 3 : int'($urandom_range(1, 3));
      demand = '0; skip_en = 0; preempt = 0; flash_mode = 0; preempt_way = 2'(pw);
      do_reset();
      for (int t = 0; t <= e + 28; t++) begin
        int ph, w;
        if (t <= c)           begin ph = 0; w = 0; end
        else if (t <= c + 5)  begin ph = 1; w = 0; end
        else if (t <= c + 7)  begin ph = 2; w = 0; end
        else if (t < e + 20)  begin ph = 0; w = pw; end
        else if (t < e + 25)  begin ph = 1; w = pw; end
        else if (t < e + 27)  begin ph = 2; w = pw; end
        else                  begin ph = 0; w = (pw + 1) % N; end
        checks++;
        if ({phase, active_way, light} !== {2'(ph), 2'(w), exp_light(N, ph, w, 0)}) begin
          errors++;
          $display("FAIL preempt c=%0d e=%0d t=%0d got ph=%0d way=%0d exp ph=%0d way=%0d", c, e, t, phase, active_way, ph, w);
        end
        preempt = (t >= c) && (t < e);
        tick();
      end
      preempt = 0;
    end
  endtask

  task automatic test_flash();
    for (int it = 0; it < 2; it++) begin
      int c, e;
      c = (it == 0) ? 46 : int'($urandom_range(27, 45));
      e = c + 8 + int'($urandom_range(0, 20));
      demand = '0; skip_en = 0; preempt = 0; flash_mode = 0; preempt_way = '0;
      do_reset();
      for (int t = 0; t <= e + 27; t++) begin
        int ph, w;
        bit blink;
        blink = 0;
        if (t < SLOT)         begin ph = slot_phase(t); w = 0; end
        else if (t <= c)      begin ph = 0; w = 1; end
        else if (t <= c + 5)  begin ph = 1; w = 1; end
        else if (t <= c + 7)  begin ph = 2; w = 1; end
        else if (t <= e)      begin ph = 3; w = 1; blink = (((t - c - 8) / FH) % 2) == 0; end
        else if (t <= e + 2)  begin ph = 2; w = 1; end
        else if (t <= e + 22) begin ph = 0; w = 0; end
        else                  begin ph = 1; w = 0; end
        checks++;
        if ({phase, active_way, light} !== {2'(ph), 2'(w), exp_light(N, ph, w, blink)}) begin
          errors++;
          $display("FAIL flash c=%0d e=%0d t=%0d got ph=%0d way=%0d light=%b exp ph=%0d way=%0d", c, e, t, phase, active_way, light, ph, w);
        end
        flash_mode = (t >= c) && (t < e);
        if (t >= c + 6 && t < e + 3) begin
          preempt = 1'($urandom); preempt_way = 2'($urandom);
          demand = 4'($urandom); skip_en = 1'($urandom);
        end else begin
          preempt = 0; skip_en = 0; demand = '0;
        end
        tick();
      end
    end
  endtask

  task automatic test_reset_midyellow();
    int tr;
    demand = '0; skip_en = 0; preempt = 0; flash_mode = 0;
    do_reset();
    tr = int'($urandom_range(74, 78));
    for (int t = 0; t < tr; t++) tick();
    checks++;
    if ({phase, active_way} !== {2'd1, 2'd2}) begin
      errors++; $display("FAIL pre_reset_yellow got ph=%0d way=%0d exp ph=1 way=2", phase, active_way);
    end
    preempt = 1; preempt_way = 2'($urandom_range(1, 3)); rst = 1;
    tick();
    rst = 0; preempt = 0;
    for (int t = 0; t <= SLOT; t++) begin
      int ph, w;
      ph = slot_phase(t % SLOT);
      w  = t / SLOT;
      checks++;
      if ({phase, active_way, light} !== {2'(ph), 2'(w), exp_light(N, ph, w, 0)}) begin
        errors++;
        $display("FAIL reset_midyellow t=%0d got ph=%0d way=%0d exp ph=%0d way=%0d", t, phase, active_way, ph, w);
      end
      tick();
    end
  endtask

  task automatic test_small();
    int w, nw;
    logic [11:0] el;
    demand_b = '0; skip_en_b = 0; preempt_b = 0; preempt_way_b = 2'd3; flash_b = 0;
    rst_b = 1;
    tick();
    rst_b = 0;
    w = 0;
    for (int t = 0; t < 90; t++) begin
      el = exp_light(3, t % 3, w, 0);
      checks++;
      if ({phase_b, active_way_b, light_b} !== {2'(t % 3), 2'(w), el[8:0]}) begin
        errors++;
        $display("FAIL small t=%0d got ph=%0d way=%0d light=%b exp ph=%0d way=%0d light=%b", t, phase_b, active_way_b, light_b, t % 3, w, el[8:0]);
      end
      checks++;
      if (nonred({3'b001, light_b}, 4) > 1) begin
        errors++; $display("FAIL small_excl t=%0d got light=%b exp at most one non-red", t, light_b);
      end
      demand_b = 3'($urandom); skip_en_b = 1'($urandom); preempt_b = 1'($urandom);
      nw = (w + 1) % 3;
      if (skip_en_b && demand_b != 0) begin
        for (int d = 3; d >= 1; d--) if (demand_b[(w + d) % 3]) nw = (w + d) % 3;
      end
      tick();
      if (t % 3 == 2) w = nw;
    end
  endtask

  initial begin
    rst = 1; rst_b = 1;
    demand = '0; skip_en = 0; preempt = 0; preempt_way = '0; flash_mode = 0;
    demand_b = '0; skip_en_b = 0; preempt_b = 0; preempt_way_b = '0; flash_b = 0;
    @(negedge clk);
    test_reset();
    test_rotation();
    test_skip();
    test_preempt();
    test_flash();
    test_reset_midyellow();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl_param.md
# traffic_light_ctrl_param

Parametrised N-approach intersection controller that sequences green, yellow and all-red clearance phases round-robin across `NUM_WAYS` approaches. Each phase has its own duration counter. Optional features: demand-based skipping of idle approaches, emergency preemption toward a selected approach, and a night flashing mode. Sits at the top of the traffic subsystem and drives the lamp drivers directly.

## Interface
- `NUM_WAYS`, 4: number of approaches, ≥2.
- `GREEN_CYC`, 20: green duration in cycles, ≥1.
- `YELLOW_CYC`, 5: yellow duration in cycles, ≥1.
- `ALLRED_CYC`, 2: all-red clearance duration in cycles, ≥1.
- `FLASH_HALF`, 8: flash half-period in cycles, ≥1.
- Derived localparams:
  - `IW = max(1, clog2(NUM_WAYS))`.
  - Timer width `TW = clog2(max of the four durations)+1`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `demand` in NUM_WAYS: per-approach vehicle-present flags; bit i is approach i.
- `skip_en` in 1: when 1, approaches without demand are skipped.
- `preempt` in 1: emergency preemption request, level-sensitive.
- `preempt_way` in IW: approach to be served by preemption; values ≥NUM_WAYS are ignored (treated as no preempt).
- `flash_mode` in 1: request night flashing mode, level-sensitive.
- `light` out 3*NUM_WAYS: lamp outputs.
  - Approach i occupies bits [3*(NUM_WAYS-1-i)+2 : 3*(NUM_WAYS-1-i)], so approach 0 is the MSB group.
  - Per group: 100 = green, 010 = yellow, 001 = red, 000 = dark (flash off half only).
- `active_way` out IW: approach currently owning (or last owning) green.
- `phase` out 2: 00 GREEN, 01 YELLOW, 10 ALLRED, 11 FLASH.

## Operation
- **Registered state:** `phase`, `active_way`, phase timer, flash blink bit, latched target. `light` is a pure decode of these registers and never glitches across phases.
- **Lamp decode:**
  - GREEN: active approach 100, all others 001.
  - YELLOW: active approach 010, all others 001.
  - ALLRED: every approach 001.
  - FLASH: every approach 010 when blink=1, 000 when blink=0.
- **Phase timer:** cleared to 0 on every phase entry and increments each cycle.
- **GREEN → YELLOW** when any of these hold:
  - timer == GREEN_CYC-1.
  - `preempt` is valid and `preempt_way` != `active_way`.
  - `flash_mode` == 1.
- **Preempt hold in GREEN:** if `preempt` is valid and `preempt_way` == `active_way`, the timer freezes and green holds for as long as `preempt` stays high. Resume counting from the frozen value afterward.
- **YELLOW → ALLRED** at timer == YELLOW_CYC-1. Yellow is never truncated.
- **ALLRED exit** at timer == ALLRED_CYC-1, with priority in this order:
  1. `flash_mode` → FLASH.
  2. Valid `preempt` → GREEN on `preempt_way`.
  3. `skip_en` and `demand` != 0 → GREEN on the first approach with demand, searching from `active_way`+1 upward with wrap. This may select `active_way` itself if it is the only one with demand.
  4. Otherwise → GREEN on (`active_way`+1) mod NUM_WAYS.
- **FLASH:**
  - Blink bit starts at 1 on entry and toggles every FLASH_HALF cycles.
  - `preempt`, `demand` and `skip_en` are ignored.
  - When `flash_mode` drops to 0: → ALLRED (full ALLRED_CYC), then GREEN on approach 0 regardless of the usual priority, and `active_way` updates to 0.
- **Sampling rule:** all inputs are sampled only on the evaluating edge. A preempt or flash request that rises and falls within YELLOW or ALLRED has effect only if it is still high at the ALLRED exit edge. A truncation caused by preempt or flash in GREEN is never undone.
- **`active_way`** changes only on the ALLRED→GREEN edge.

## Timing
- **Reset** (rst high at an edge):
  - phase = GREEN, `active_way` = 0, timer = 0, blink = 1.
  - `light` = {100, 001, 001, 001} for the default parameters.
  - `rst` overrides everything, including mid-yellow, mid-flash and active preempt.
- **Nominal dwell:** green exactly GREEN_CYC cycles, yellow YELLOW_CYC, all-red ALLRED_CYC. A full unskipped rotation is NUM_WAYS*(G+Y+AR) cycles = 108 with defaults.
- **Preempt latency:** preempt asserted at edge k in GREEN of another approach gives YELLOW visible after edge k. The preempted approach turns green after exactly YELLOW_CYC+ALLRED_CYC further cycles.
- **Flash entry latency:**
  - From GREEN: ≤ YELLOW_CYC+ALLRED_CYC+1 cycles.
  - From YELLOW/ALLRED: the remaining cycles of those phases.
- **Simultaneous events:**
  - flash beats preempt.
  - preempt beats skip.
  - A natural green expiry and a preempt on the same edge give a single YELLOW entry.
- **Invariant:** no two approaches are ever non-red simultaneously, except all-yellow in FLASH.

## Test plan
- Reset, then run 108 cycles with `skip_en`=0 → green on 0,1,2,3, each exactly 20 cycles, with 5 yellow and 2 all-red between; back to approach 0 green at cycle 108.
- `skip_en`=1, `demand`=4'b0100 from reset → after approach 0's green/yellow/all-red (27 cycles), approach 2 goes green. Approach 2 is then re-served repeatedly, 27-cycle cycle.
- `preempt`=1, `preempt_way`=3 at cycle 5 of approach 0 green → yellow at cycle 6, approach 3 green at cycle 13. Green holds while `preempt` stays high, then finishes the remaining 20 cycles after release.
- `flash_mode`=1 mid-green → yellow, all-red, then all groups alternate 010/000 every 8 cycles. Dropping `flash_mode` gives 2 cycles all-red, then approach 0 green.
- `rst` pulsed during yellow of approach 2 with `preempt` high → next cycle phase = GREEN, `active_way` = 0, timer = 0.
- `NUM_WAYS`=3, `GREEN_CYC`=1, `YELLOW_CYC`=1, `ALLRED_CYC`=1 → 9-cycle rotation, 9-bit `light`. Check the mutual-exclusion invariant every cycle.
